// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store unit over a request/grant data bus
//
// Takes the ALU result as effective address and performs LB/LH/LW/LBU/LHU/SB/SH/SW.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses fault
// instead of going to the bus; when undefined Misalign is tied 0).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   MemRead, MemWrite          load / store request (store wins)
//   Funct3                     access size / signedness
//   ALUResult, WrData          effective address, store data
//   Stall                      holds PC and register-file write while busy
//   RdData                     extended load result (holds between loads)
//   Misalign                   misaligned-access fault pulse
//   bus_req/we/addr/be/wdata   registered bus request
//   bus_gnt, bus_rvalid, bus_rdata  bus responses
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic                  Stall,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  Misalign,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t                state_q;
    logic                  bus_req_q;
    logic                  bus_we_q;
    logic [3:0]            bus_be_q;
    logic [DATA_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;

    logic                  access;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] load_d;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign access = MemRead | MemWrite;
    assign Stall  = access && (state_q != DONE);

    // Size decode: Funct3[1:0] 00 = byte, 01 = half, anything else = word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WrData;
        case (Funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ALUResult[1:0];
                wdata_d = {4{WrData[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {ALUResult[1], 1'b0};
                wdata_d = {2{WrData[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane extraction uses the address offset captured at request time.
    always_comb begin
        byte_sel = bus_rdata[7:0];
        case (addr_lo_q)
            2'd0: byte_sel = bus_rdata[7:0];
            2'd1: byte_sel = bus_rdata[15:8];
            2'd2: byte_sel = bus_rdata[23:16];
            2'd3: byte_sel = bus_rdata[31:24];
            default: ;
        endcase
        half_sel = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_d   = bus_rdata;
        case (funct3_q[1:0])
            2'b00:   load_d = funct3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_d = funct3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_d = bus_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_d;
    logic misalign_q;
    assign fault_d  = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                      (Funct3[1] && (ALUResult[1:0] != 2'b00));
    assign Misalign = misalign_q;
`else
    assign Misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rd_data_q   <= '0;
            funct3_q    <= 3'b0;
            addr_lo_q   <= 2'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (access && fault_d) begin
                        misalign_q <= 1'b1;
                        state_q    <= DONE;
                    end else
`endif
                    if (access) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= MemWrite;
                        bus_be_q    <= be_d;
                        bus_addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        bus_wdata_q <= wdata_d;
                        funct3_q    <= Funct3;
                        addr_lo_q   <= ALUResult[1:0];
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= bus_we_q ? DONE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        rd_data_q <= load_d;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_q <= 1'b0;
`endif
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign RdData    = rd_data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit directly downstream of the ALU in the RISC-V datapath. It takes the ALU result as the effective address and performs LB/LH/LW/LBU/LHU/SB/SH/SW over a request/grant data bus. It stalls the core while an access is outstanding and returns the aligned, extended load value to the writeback mux.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width; the byte-lane logic is defined for 32 only.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store; wins over MemRead if both are high
- Funct3  in  3  instr[14:12]: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- ALUResult  in  DATA_WIDTH  effective address
- WrData  in  DATA_WIDTH  rs2 store data
- Stall  out  1  hold the PC and register-file write
- RdData  out  DATA_WIDTH  extended load result
- Misalign  out  1  misaligned-access fault pulse
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  DATA_WIDTH  word-aligned address ({ALUResult[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  DATA_WIDTH  lane-replicated store data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid; never in the same cycle as bus_gnt
- bus_rdata  in  DATA_WIDTH  read data word

## Operation
- States: IDLE, REQ, WAIT_R, DONE.
- Stall = (MemRead|MemWrite) && state != DONE. Stall is combinational.
- **IDLE:**
  - If MemRead|MemWrite, register address, we, be and wdata, then go to REQ.
  - With a misalign fault enabled and detected (see Configuration), go to DONE instead.
- **REQ:** bus_req=1. On bus_gnt, a write goes to DONE and a read goes to WAIT_R.
- **WAIT_R:** on bus_rvalid, capture the extracted, extended lane into RdData and go to DONE.
- **DONE:** Stall=0 for exactly one cycle, then go to IDLE. A back-to-back memory instruction restarts from IDLE.
- **Byte enables:**
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- **Store data:** byte is {4{WrData[7:0]}}; half is {2{WrData[15:0]}}; word is WrData.
- **Load extraction:**
  - byte lane is addr[1:0]; half lane is addr[1].
  - 000/001 sign-extend; 100/101 zero-extend.
  - Any other Funct3 value is treated as word.
- RdData updates only on a completed load and holds otherwise. Stores do not change it.
- bus_rdata is ignored outside WAIT_R. A stray bus_gnt or bus_rvalid in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, RdData and Misalign all 0.
- Store latency with gnt in the first REQ cycle: 3 cycles (IDLE, REQ, DONE). Stall is high for 2.
- Load latency with gnt immediate and rvalid on the next cycle: 4 cycles (IDLE, REQ, WAIT_R, DONE).
- Each cycle of gnt or rvalid delay adds one cycle. There is no timeout.
- bus_addr, bus_we, bus_be and bus_wdata are registered and stable from REQ entry until the gnt cycle.
- **Reset mid-access:** the FSM returns to IDLE immediately (asynchronous) and bus_req drops without waiting for gnt. A late rvalid after reset is ignored.
- Inputs must be held stable while Stall=1. Behaviour with inputs changing mid-access is undefined.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is a fault.
  - A fault issues no bus request; the FSM goes IDLE→DONE (Stall for 1 cycle).
  - Misalign=1 during that DONE cycle only; RdData is unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misalign is tied 0.
  - Offending low address bits are ignored (half uses addr[1] only; word uses neither).
  - The access proceeds normally.

## Test plan
- SW to 0x100 with WrData=0xDEADBEEF, gnt immediate → bus_addr=0x100, bus_be=4'hF, bus_wdata=0xDEADBEEF, bus_we=1; Stall high 2 cycles then low 1.
- SB to 0x103 with WrData=0x000000A5 → bus_addr=0x100, bus_be=4'b1000, bus_wdata=0xA5A5A5A5.
- LB from 0x102, bus_rdata=0x12F45678, rvalid 3 cycles after gnt → RdData=0xFFFFFFF4. Repeat as LBU → RdData=0x000000F4.
- LH from 0x102, bus_rdata=0x8001FFFF → RdData=0xFFFF8001. LHU → 0x00008001.
- LW from 0x101: with LSU_MISALIGN_TRAP_EN → no bus_req, Misalign pulses 1 cycle, RdData unchanged. Without it → bus_addr=0x100 and a normal load.
- Assert reset while in WAIT_R → bus_req=0, Stall=MemRead|MemWrite, and a later rvalid does not change RdData (stays 0).
